// File: rtl/smartflow_pkg.sv
// Shared lane-scheduling types: arbiter FSM states and density levels.
// Density encoding is common to the arbiter and every lane_fsm.
package smartflow_pkg;

  localparam int DENS_W = 2;

  typedef enum logic [DENS_W-1:0] {
    DENS_NONE = 2'd0,
    DENS_LOW  = 2'd1,
    DENS_MED  = 2'd2,
    DENS_HIGH = 2'd3
  } density_e;

  typedef enum logic [2:0] {
    S_CLEAR      = 3'd0,
    S_ARB        = 3'd1,
    S_GRANT      = 3'd2,
    S_WAIT_LEAVE = 3'd3,
    S_WAIT_DONE  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/intersection_arbiter_if.sv
// Arbiter <-> lane bundle: lane demand/red status in, grant status out.
// The arbiter side is master, the lane side is slave.
interface intersection_arbiter_if #(
  parameter int NUM_LANES = 4
);
  localparam int IDX_W = $clog2(NUM_LANES);

  logic [2*NUM_LANES-1:0] density;
  logic [NUM_LANES-1:0]   lane_red;
  logic [NUM_LANES-1:0]   grant;
  logic [IDX_W-1:0]       active_lane;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    input  density,
    input  lane_red,
    output grant,
    output active_lane,
    output busy,
    output timeout_err
  );

  modport slave (
    output density,
    output lane_red,
    input  grant,
    input  active_lane,
    input  busy,
    input  timeout_err
  );

endinterface

// File: rtl/intersection_arbiter_rr_prio_pick.sv
// Combinational winner picker: starved lanes first, then densest,
// ties broken by round-robin order starting after rr_ptr.
module rr_prio_pick
  import smartflow_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] eligible,
  input  logic [NUM_LANES-1:0] starved,
  input  logic [DENS_W-1:0]    dens [NUM_LANES],
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_LANES);

  logic [IDX_W:0]    pos;
  logic [IDX_W-1:0]  idx;
  logic              s_hit;
  logic [IDX_W-1:0]  s_idx;
  logic              d_hit;
  logic [IDX_W-1:0]  d_idx;
  logic [DENS_W-1:0] d_best;

  always_comb begin
    pos    = '0;
    idx    = '0;
    s_hit  = 1'b0;
    s_idx  = '0;
    d_hit  = 1'b0;
    d_idx  = '0;
    d_best = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (pos >= N_EXT)
        pos = pos - N_EXT;
      idx = pos[IDX_W-1:0];
      if (!s_hit && eligible[idx] && starved[idx]) begin
        s_hit = 1'b1;
        s_idx = idx;
      end
      // strict '>' keeps the earliest lane in search order on a tie
      if (eligible[idx] && (!d_hit || dens[idx] > d_best)) begin
        d_hit  = 1'b1;
        d_idx  = idx;
        d_best = dens[idx];
      end
    end
    valid  = d_hit;
    winner = s_hit ? s_idx : d_idx;
  end

endmodule

// File: rtl/intersection_arbiter.sv
// Green-phase scheduler for the lane_fsm array: all-red clearance,
// density/age/round-robin arbitration, grant pulse and ack timeout.
module intersection_arbiter
  import smartflow_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int ALL_RED_CYCLES = 3,
  parameter int STARVE_LIMIT   = 3,
  parameter int AGE_W          = 4,
  parameter int ACK_TIMEOUT    = 4
) (
  input logic                    clk,
  input logic                    reset,
  intersection_arbiter_if.master bus
);

  localparam int IDX_W  = $clog2(NUM_LANES);
  localparam int CLR_W  = $clog2(ALL_RED_CYCLES + 1);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT);

  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(ALL_RED_CYCLES - 1);
  localparam logic [WAIT_W-1:0] TO_LAST  = WAIT_W'(ACK_TIMEOUT - 2);
  localparam logic [AGE_W-1:0]  AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0]  STARVE   = AGE_W'(STARVE_LIMIT);
  localparam logic [NUM_LANES-1:0] ONE   = NUM_LANES'(1);

  arb_state_e        state;
  logic [CLR_W-1:0]  clear_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [AGE_W-1:0]  age [NUM_LANES];

  logic [DENS_W-1:0]    dens [NUM_LANES];
  logic [NUM_LANES-1:0] elig;
  logic [NUM_LANES-1:0] starved;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign dens[i]    = bus.density[DENS_W*i +: DENS_W];
    assign elig[i]    = dens[i] != DENS_NONE;
    assign starved[i] = age[i] >= STARVE;
  end

  rr_prio_pick #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_pick (
    .eligible (elig),
    .starved  (starved),
    .dens     (dens),
    .rr_ptr   (rr_ptr),
    .winner   (pick_idx),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_CLEAR;
      clear_cnt       <= '0;
      wait_cnt        <= '0;
      rr_ptr          <= IDX_W'(NUM_LANES - 1);
      bus.grant       <= '0;
      bus.active_lane <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++)
        age[i] <= '0;
    end else begin
      bus.grant       <= '0;
      bus.timeout_err <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          if (&bus.lane_red) begin
            if (clear_cnt == CLR_LAST) begin
              clear_cnt <= '0;
              state     <= S_ARB;
            end else begin
              clear_cnt <= clear_cnt + CLR_W'(1);
            end
          end else begin
            clear_cnt <= '0;
          end
        end
        S_ARB: begin
          if (pick_valid) begin
            bus.grant       <= ONE << pick_idx;
            bus.active_lane <= pick_idx;
            bus.busy        <= 1'b1;
            rr_ptr          <= pick_idx;
            state           <= S_GRANT;
            // losers with demand age; idle lanes hold their age
            for (int i = 0; i < NUM_LANES; i++) begin
              if (IDX_W'(i) == pick_idx)
                age[i] <= '0;
              else if (elig[i] && age[i] != AGE_MAX)
                age[i] <= age[i] + AGE_W'(1);
            end
          end
        end
        S_GRANT: begin
          wait_cnt <= '0;
          state    <= S_WAIT_LEAVE;
        end
        S_WAIT_LEAVE: begin
          if (!bus.lane_red[bus.active_lane]) begin
            state <= S_WAIT_DONE;
          end else if (wait_cnt == TO_LAST) begin
            bus.timeout_err <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= S_CLEAR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (bus.lane_red[bus.active_lane]) begin
            bus.busy <= 1'b0;
            state    <= S_CLEAR;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule
